fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// the width helper used for the owner index and the beat counter.
package fifo_wr_arbiter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  // Ceiling log2 with a floor of one bit, so a 2-entry range still gets a bit.
  function automatic int ceil_log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first eligible requester at or
// after i_start (wrapping), optionally skipping one excluded index.
module rr_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = ceil_log2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  input  logic            i_excl_en,
  input  logic [IW-1:0]   i_excl_idx,
  output logic            o_found,
  output logic [IW-1:0]   o_idx
);

  localparam logic [IW:0] N_L = (IW+1)'(NREQ);

  logic [IW:0] w_best;
  logic [IW:0] w_dist;

  // Each candidate is ranked by its wrapped distance from i_start; the
  // smallest distance wins, which is the upward scan with wrap-around.
  always_comb begin
    // NOTE: every output and temporary gets a default before any branch so
    // no path leaves a value held, which would infer a latch.
    o_found = 1'b0;
    o_idx   = '0;
    w_best  = N_L;
    w_dist  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) >= i_start) w_dist = (IW+1)'(i) - {1'b0, i_start};
      else                   w_dist = (IW+1)'(i) + N_L - {1'b0, i_start};
      if (i_req[i] && !(i_excl_en && (i_excl_idx == IW'(i))) && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting NREQ requesters burst tenures on a single
// shared FIFO write port; the grant holder's word is written whenever not full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  parameter  int BURST = 4,
  localparam int OW    = ceil_log2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  localparam int            CW        = ceil_log2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  state_t        r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_rr_ptr;
  logic [CW-1:0] r_beat_cnt;

  logic             w_grant;
  logic             w_owner_req;
  logic [WIDTH-1:0] w_owner_data;
  logic             w_last;
  logic             w_end;
  logic [OW-1:0]    w_next_ptr;
  logic [OW-1:0]    w_pick_start;
  logic             w_found;
  logic [OW-1:0]    w_pick_idx;

  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_owner_req  = req[i];
        w_owner_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_grant = (r_state == ST_GRANT);
  assign winc    = w_grant & w_owner_req & ~wfull;
  assign wdata   = w_grant ? w_owner_data : '0;
  assign busy    = w_grant;
  assign owner   = r_owner;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = winc && (r_owner == OW'(i));
    end
  end

  // A stalled (wfull) cycle never ends a tenure; only the last beat or a
  // withdrawn request does.
  assign w_last     = winc && (r_beat_cnt == LAST_BEAT);
  assign w_end      = w_grant && (!w_owner_req || w_last);
  assign w_next_ptr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);

  // One picker serves both cases: from rr_ptr when idle, and from the slot
  // after the outgoing owner (excluding it) when a tenure ends.
  assign w_pick_start = w_grant ? w_next_ptr : r_rr_ptr;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_picker (
    .i_req      (req),
    .i_start    (w_pick_start),
    .i_excl_en  (w_grant),
    .i_excl_idx (r_owner),
    .o_found    (w_found),
    .o_idx      (w_pick_idx)
  );

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_found) begin
        r_state    <= ST_GRANT;
        r_owner    <= w_pick_idx;
        r_beat_cnt <= '0;
      end
    end else begin
      if (w_end) begin
        r_rr_ptr   <= w_next_ptr;
        r_beat_cnt <= '0;
        if (w_found) r_owner <= w_pick_idx;
        else         r_state <= ST_IDLE;
      end else if (winc) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
    end
  end

endmodule
